// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if
//   Groups the E-stage request signals and the HI/LO/Busy results of the
//   multiply/divide unit into one bundle.
//   master : the pipeline side; drives the requests and reads HI, LO, Busy.
//   slave  : the mul_div_unit side.
//   Signals:
//     Start  launch a multiply/divide this cycle
//     MDOp   00 mult, 01 multu, 10 div, 11 divu
//     MtHi   write A into HI
//     MtLo   write A into LO
//     Flush  exception/interrupt; cancels this cycle's requests
//     A, B   operands (A is also the mthi/mtlo source)
//     HI, LO architectural result registers
//     Busy   stall request, high while an operation is pending or launching
interface mul_div_unit_if;
  logic        Start;
  logic [1:0]  MDOp;
  logic        MtHi;
  logic        MtLo;
  logic        Flush;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;

  modport master (
    output Start, MDOp, MtHi, MtLo, Flush, A, B,
    input  HI, LO, Busy
  );

  modport slave (
    input  Start, MDOp, MtHi, MtLo, Flush, A, B,
    output HI, LO, Busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Multicycle multiply/divide unit with architectural HI/LO registers.
//   A Start in IDLE latches the operands and runs for 5 cycles (mult/multu)
//   or 10 cycles (div/divu); HI/LO are written at the last edge of the run.
//   mthi/mtlo write HI/LO directly when the unit is idle.
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-low reset
//     bus    mul_div_unit_if.slave (Start, MDOp, MtHi, MtLo, Flush, A, B in;
//            HI, LO, Busy out)
//   Configuration:
//     MDU_DIV_EN  when defined, div/divu are supported; when undefined, the
//                 divider is not built and MDOp 10/11 requests are ignored.
module mul_div_unit (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [1:0]  opQ;
  logic [31:0] aQ, bQ;
  logic [31:0] hiQ, hiD;
  logic [31:0] loQ, loD;

  logic        opOk;
  logic        accept;
  logic        mtOk;
  logic        done;
  logic        signedOp;
  logic [63:0] aExt, bExt, prod;
  logic [31:0] resHi, resLo;
  logic        resValid;

`ifdef MDU_DIV_EN
  assign opOk = 1'b1;
`else
  assign opOk = ~bus.MDOp[1];
`endif

  assign accept = (stateQ == IDLE) & bus.Start & ~bus.Flush & opOk;
  // Start has priority over mthi/mtlo issued in the same cycle
  assign mtOk   = (stateQ == IDLE) & ~bus.Start & ~bus.Flush;
  assign done   = (stateQ == RUN) & (cntQ == 4'd1);

  assign bus.Busy = accept | (stateQ == RUN);
  assign bus.HI   = hiQ;
  assign bus.LO   = loQ;

  // One 64x64 multiplier serves both mult and multu: sign-extending the
  // operands for mult makes the low 64 bits the signed product
  assign signedOp = ~opQ[0];
  assign aExt     = {{32{signedOp & aQ[31]}}, aQ};
  assign bExt     = {{32{signedOp & bQ[31]}}, bQ};
  assign prod     = aExt * bExt;

`ifdef MDU_DIV_EN
  logic        aNeg, bNeg;
  logic [31:0] aMag, bMag, bSafe, qMag, rMag, quot, rem;

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero and the remainder follows the dividend
  assign aNeg  = signedOp & aQ[31];
  assign bNeg  = signedOp & bQ[31];
  assign aMag  = aNeg ? (32'd0 - aQ) : aQ;
  assign bMag  = bNeg ? (32'd0 - bQ) : bQ;
  // A zero divisor never writes back; substitute 1 to keep the divider defined
  assign bSafe = (bMag == 32'd0) ? 32'd1 : bMag;
  assign qMag  = aMag / bSafe;
  assign rMag  = aMag % bSafe;
  assign quot  = (aNeg ^ bNeg) ? (32'd0 - qMag) : qMag;
  assign rem   = aNeg ? (32'd0 - rMag) : rMag;

  assign resHi    = opQ[1] ? rem  : prod[63:32];
  assign resLo    = opQ[1] ? quot : prod[31:0];
  assign resValid = ~opQ[1] | (bQ != 32'd0);
`else
  assign resHi    = prod[63:32];
  assign resLo    = prod[31:0];
  assign resValid = ~opQ[1];
`endif

  // State register and run counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Next state: load the run length on accept, count down to 1 in RUN
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (accept) begin
          stateD = RUN;
          cntD   = bus.MDOp[1] ? 4'd10 : 4'd5;
        end
      end
      RUN: begin
        cntD = cntQ - 4'd1;
        if (cntQ == 4'd1) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Output logic: result write-back at the end of a run, else mthi/mtlo
  always_comb begin
    hiD = hiQ;
    loD = loQ;
    if (done) begin
      if (resValid) begin
        hiD = resHi;
        loD = resLo;
      end
    end else if (mtOk) begin
      if (bus.MtHi) hiD = bus.A;
      if (bus.MtLo) loD = bus.A;
    end
  end

  // Operand latches and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opQ <= 2'b00;
      aQ  <= 32'd0;
      bQ  <= 32'd0;
      hiQ <= 32'd0;
      loQ <= 32'd0;
    end else begin
      if (accept) begin
        opQ <= bus.MDOp;
        aQ  <= bus.A;
        bQ  <= bus.B;
      end
      hiQ <= hiD;
      loQ <= loD;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
//   Directed bench for mul_div_unit. Inputs change on the falling edge and
//   outputs are sampled there too, half a period away from the active edge.
//   Division vectors run only when MDU_DIV_EN is defined; otherwise the
//   bench checks that div requests are ignored.
module tb_mul_div_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] expHi;
  logic [31:0] expLo;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Return all request inputs to their inactive values
  task automatic clearInputs();
    bus.Start = 1'b0;
    bus.MDOp  = 2'b00;
    bus.MtHi  = 1'b0;
    bus.MtLo  = 1'b0;
    bus.Flush = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
  endtask

  // Issue one operation at the current falling edge and follow it to the
  // end. With disturb set, cycle 2 carries Start/Flush/mthi/mtlo that must
  // all be ignored while the unit is running.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [31:0] newHi,
                               input logic [31:0] newLo, input bit disturb);
    bus.Start = 1'b1;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    #1 checkOutput({tag, " busy c0"}, {31'd0, bus.Busy}, 32'd1);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      clearInputs();
      if (disturb && c == 2) begin
        bus.Start = 1'b1;
        bus.Flush = 1'b1;
        bus.MtHi  = 1'b1;
        bus.MtLo  = 1'b1;
        bus.A     = 32'hDEAD_BEEF;
      end
      #1;
      checkOutput($sformatf("%s busy c%0d", tag, c), {31'd0, bus.Busy}, 32'd1);
      checkOutput($sformatf("%s hi hold c%0d", tag, c), bus.HI, expHi);
      checkOutput($sformatf("%s lo hold c%0d", tag, c), bus.LO, expLo);
    end
    @(negedge clk);
    clearInputs();
    expHi = newHi;
    expLo = newLo;
    #1;
    checkOutput({tag, " busy done"}, {31'd0, bus.Busy}, 32'd0);
    checkOutput({tag, " hi"}, bus.HI, expHi);
    checkOutput({tag, " lo"}, bus.LO, expLo);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    expHi  = 32'd0;
    expLo  = 32'd0;
    clearInputs();
    reset = 1'b0;

    // Reset state, and Busy following Start while held in reset
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset hi", bus.HI, 32'd0);
    checkOutput("reset lo", bus.LO, 32'd0);
    checkOutput("reset busy", {31'd0, bus.Busy}, 32'd0);
    bus.Start = 1'b1;
    #1 checkOutput("reset busy start", {31'd0, bus.Busy}, 32'd1);
    @(negedge clk);
    clearInputs();
    checkOutput("reset start ignored", bus.LO, 32'd0);
    reset = 1'b1;

    // mthi, mtlo, and both together
    @(negedge clk);
    bus.MtHi = 1'b1;
    bus.A    = 32'h0000_0011;
    @(negedge clk);
    clearInputs();
    checkOutput("mthi hi", bus.HI, 32'h0000_0011);
    checkOutput("mthi lo", bus.LO, 32'h0000_0000);
    bus.MtHi = 1'b1;
    bus.MtLo = 1'b1;
    bus.A    = 32'h0000_00AB;
    @(negedge clk);
    clearInputs();
    checkOutput("mthilo hi", bus.HI, 32'h0000_00AB);
    checkOutput("mthilo lo", bus.LO, 32'h0000_00AB);
    bus.MtLo  = 1'b1;
    bus.Flush = 1'b1;
    bus.A     = 32'h0000_0055;
    @(negedge clk);
    clearInputs();
    checkOutput("mtlo flushed", bus.LO, 32'h0000_00AB);
    expHi = 32'h0000_00AB;
    expLo = 32'h0000_00AB;

    // Multiplies
    @(negedge clk);
    applyStimulus("mult neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 5,
                  32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    @(negedge clk);
    applyStimulus("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                  32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    applyStimulus("mult minint", 2'b00, 32'h8000_0000, 32'h0000_0002, 5,
                  32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    @(negedge clk);
    applyStimulus("multu minint", 2'b01, 32'h8000_0000, 32'h0000_0002, 5,
                  32'h0000_0001, 32'h0000_0000, 1'b0);

    // Start with Flush is dropped; the next cycle's Start goes through
    @(negedge clk);
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    bus.A     = 32'h0000_0007;
    bus.B     = 32'h0000_0007;
    #1 checkOutput("flush busy", {31'd0, bus.Busy}, 32'd0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("flush idle busy", {31'd0, bus.Busy}, 32'd0);
    checkOutput("flush hi", bus.HI, expHi);
    checkOutput("flush lo", bus.LO, expLo);
    applyStimulus("after flush", 2'b00, 32'h0000_0007, 32'h0000_0007, 5,
                  32'h0000_0000, 32'h0000_0031, 1'b0);

    // Start wins over a simultaneous mthi
    @(negedge clk);
    bus.MtHi = 1'b1;
    applyStimulus("start+mthi", 2'b00, 32'h0000_0003, 32'h0000_0004, 5,
                  32'h0000_0000, 32'h0000_000C, 1'b0);

`ifdef MDU_DIV_EN
    @(negedge clk);
    applyStimulus("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 10,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    @(negedge clk);
    applyStimulus("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10,
                  32'h0000_0000, 32'h8000_0000, 1'b0);
    @(negedge clk);
    applyStimulus("div 7/-2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 10,
                  32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    applyStimulus("divu big/16", 2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 10,
                  32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    @(negedge clk);
    bus.MtHi = 1'b1;
    bus.A    = 32'h0000_0011;
    @(negedge clk);
    clearInputs();
    bus.MtLo = 1'b1;
    bus.A    = 32'h0000_0022;
    @(negedge clk);
    clearInputs();
    expHi = 32'h0000_0011;
    expLo = 32'h0000_0022;
    applyStimulus("divu by 0", 2'b11, 32'h0000_0005, 32'h0000_0000, 10,
                  32'h0000_0011, 32'h0000_0022, 1'b0);
`else
    // Division requests are ignored when the divider is not built
    @(negedge clk);
    bus.Start = 1'b1;
    bus.MDOp  = 2'b10;
    bus.A     = 32'h0000_0008;
    bus.B     = 32'h0000_0002;
    #1 checkOutput("nodiv busy c0", {31'd0, bus.Busy}, 32'd0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      clearInputs();
      #1;
      checkOutput($sformatf("nodiv busy c%0d", c), {31'd0, bus.Busy}, 32'd0);
      checkOutput($sformatf("nodiv hi c%0d", c), bus.HI, expHi);
      checkOutput($sformatf("nodiv lo c%0d", c), bus.LO, expLo);
    end
    applyStimulus("after nodiv", 2'b01, 32'h0000_0009, 32'h0000_0009, 5,
                  32'h0000_0000, 32'h0000_0051, 1'b0);
`endif

    // Reset in cycle 3 of a mult aborts it; a mult right after release works
    @(negedge clk);
    bus.Start = 1'b1;
    bus.MDOp  = 2'b00;
    bus.A     = 32'h1234_5678;
    bus.B     = 32'h0000_0010;
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort hi", bus.HI, 32'd0);
    checkOutput("abort lo", bus.LO, 32'd0);
    checkOutput("abort busy", {31'd0, bus.Busy}, 32'd0);
    expHi = 32'd0;
    expLo = 32'd0;
    @(negedge clk);
    checkOutput("abort held lo", bus.LO, 32'd0);
    reset = 1'b1;
    applyStimulus("post reset", 2'b00, 32'h0000_0002, 32'h0000_0003, 5,
                  32'h0000_0000, 32'h0000_0006, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
